// File: rtl/key_press_gen_if.sv
// key_press_gen_if: request/key/status bundle between a press requester and key_press_gen.
interface key_press_gen_if;
  logic req;
  logic key;
  logic busy;
  logic done;
  modport master(output req, input key, busy, done);
  modport slave(input req, output key, busy, done);
endinterface

// File: rtl/key_press_gen.sv
// key_press_gen: synthetic press/hold/release/gap key generator on the 1 kHz tick.
// KEY_PRESS_GEN_BOUNCE_EN adds LFSR chatter bursts on the press and release edges.
module key_press_gen #(
  parameter int HOLD_MS   = 100,
  parameter int GAP_MS    = 20,
  parameter int BOUNCE_MS = 6
) (
  input logic           clk,
  input logic           rst,
  key_press_gen_if.slave bus
);
  typedef enum logic [2:0] {IDLE, BOUNCE_ON, HOLD, BOUNCE_OFF, GAP} state_t;
  localparam logic [15:0] H_LAST = 16'(HOLD_MS - 1);
  localparam logic [15:0] G_LAST = 16'(GAP_MS - 1);
  localparam logic [15:0] B_LAST = 16'(BOUNCE_MS - 1);
  state_t      state;
  logic [15:0] cnt;
  logic        last;
  logic        chat;
  logic        press_key;
  logic        release_key;
`ifdef KEY_PRESS_GEN_BOUNCE_EN
  localparam state_t PRESS   = BOUNCE_ON;
  localparam state_t RELEASE = BOUNCE_OFF;
  logic [7:0] lfsr;
  logic       shift;
  always_comb begin
    chat        = lfsr[0];
    press_key   = lfsr[0];
    release_key = lfsr[0];
    shift = ((state == IDLE || (state == GAP && last)) && bus.req) ||
            ((state == BOUNCE_ON || state == BOUNCE_OFF) && !last) ||
            (state == HOLD && last);
  end
  // Advances only on edges that load a chatter bit into key, so it is never reseeded between presses.
  always_ff @(posedge clk or posedge rst)
    if (rst) lfsr <= 8'hA5;
    else if (shift) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
`else
  localparam state_t PRESS   = HOLD;
  localparam state_t RELEASE = GAP;
  always_comb begin
    chat        = 1'b0;
    press_key   = 1'b1;
    release_key = 1'b0;
  end
`endif
  always_comb last = (state == HOLD) ? cnt == H_LAST : (state == GAP) ? cnt == G_LAST : cnt == B_LAST;
  // A request seen on the final GAP edge starts the next press at once, so busy drops for that one done cycle.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bus.key  <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      bus.busy <= state != IDLE;
      cnt      <= (state == IDLE || last) ? '0 : cnt + 16'd1;
      case (state)
        IDLE: if (bus.req) begin
          state    <= PRESS;
          bus.key  <= press_key;
          bus.busy <= 1'b1;
        end
        BOUNCE_ON: begin
          state   <= last ? HOLD : BOUNCE_ON;
          bus.key <= last ? 1'b1 : chat;
        end
        HOLD: if (last) begin
          state   <= RELEASE;
          bus.key <= release_key;
        end
        BOUNCE_OFF: begin
          state   <= last ? GAP : BOUNCE_OFF;
          bus.key <= last ? 1'b0 : chat;
        end
        GAP: if (last) begin
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= bus.req ? PRESS : IDLE;
          bus.key  <= bus.req ? press_key : 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
